// File: rtl/pwm_compare_out.sv
// pwm_compare_out: compares an external free-running N-bit counter against a
// double-buffered duty value and produces one registered PWM output.
// Duty writes land in a shadow register and are applied only at the counter
// wrap, so every period is generated with one consistent duty value.
// A run-control FSM starts and stops the output only on period boundaries.
// Optional build macro PWM_POLARITY_EN adds a pwm_pol input that inverts the
// active level and sets the idle level of pwm_out.

module pwm_compare_out #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         count_enb,
    input  logic [N-1:0] count,
    input  logic         pwm_en,
    input  logic         duty_wr,
    input  logic [N-1:0] duty_in,
`ifdef PWM_POLARITY_EN
    input  logic         pwm_pol,
`endif
    output logic         duty_pending,
    output logic         pwm_running,
    output logic         pwm_out,
    output logic         wrap_pulse
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYNC     = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [N-1:0]   shadow_duty;
    logic [N-1:0]   active_duty;
    logic           wrap;
    logic           out_active;
    logic           compare;

    // Period boundary: the counter shows all-ones and is about to advance to 0.
    assign wrap       = count_enb && (count == {N{1'b1}});
    assign out_active = (state == RUN) || (state == STOPPING);
    assign compare    = (count < active_duty);

    // Run-control next-state logic; pwm_en changes win over the wrap event.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        next_state = state;
        case (state)
            IDLE: begin
                if (pwm_en) next_state = SYNC;
            end
            SYNC: begin
                if (!pwm_en)   next_state = IDLE;
                else if (wrap) next_state = RUN;
            end
            RUN: begin
                if (!pwm_en) next_state = STOPPING;
            end
            STOPPING: begin
                if (pwm_en)    next_state = RUN;
                else if (wrap) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register plus the running flag registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset) begin
            state       <= IDLE;
            pwm_running <= 1'b0;
        end else begin
            state       <= next_state;
            pwm_running <= (next_state == RUN) || (next_state == STOPPING);
        end
    end

    // Double-buffered duty: shadow load any time, transfer only on wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_duty  <= '0;
            active_duty  <= '0;
            duty_pending <= 1'b0;
        end else if (duty_wr && wrap) begin
            // A write landing exactly on the boundary goes straight to the
            // active register and supersedes anything still in the shadow.
            active_duty  <= duty_in;
            duty_pending <= 1'b0;
        end else begin
            if (wrap && duty_pending) begin
                active_duty  <= shadow_duty;
                duty_pending <= 1'b0;
            end
            if (duty_wr) begin
                shadow_duty  <= duty_in;
                duty_pending <= 1'b1;
            end
        end
    end

    // Registered PWM compare output and the one-cycle wrap indicator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_out    <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
`ifdef PWM_POLARITY_EN
            pwm_out    <= out_active ? (compare ^ pwm_pol) : pwm_pol;
`else
            pwm_out    <= out_active && compare;
`endif
            wrap_pulse <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_compare_out.sv
// tb_pwm_compare_out: directed, table-driven bench for pwm_compare_out (N=8).
// The bench drives count directly, so vectors can jump straight to the counts
// of interest; full-period sequences then run the counter freely.

module tb_pwm_compare_out;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         count_enb;
    logic [N-1:0] count;
    logic         pwm_en;
    logic         duty_wr;
    logic [N-1:0] duty_in;
`ifdef PWM_POLARITY_EN
    logic         pwm_pol;
`endif
    logic         duty_pending;
    logic         pwm_running;
    logic         pwm_out;
    logic         wrap_pulse;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] count;
        logic         enb;
        logic         en;
        logic         wr;
        logic [N-1:0] din;
        logic         exp_out;
        logic         exp_run;
        logic         exp_pend;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[$];

    pwm_compare_out #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .count_enb    (count_enb),
        .count        (count),
        .pwm_en       (pwm_en),
        .duty_wr      (duty_wr),
        .duty_in      (duty_in),
`ifdef PWM_POLARITY_EN
        .pwm_pol      (pwm_pol),
`endif
        .duty_pending (duty_pending),
        .pwm_running  (pwm_running),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int c, input int e, input int en, input int wr,
                                input int din, input int o, input int r,
                                input int p, input int w);
        vec_t v;
        v.count    = N'(c);
        v.enb      = (e != 0);
        v.en       = (en != 0);
        v.wr       = (wr != 0);
        v.din      = N'(din);
        v.exp_out  = (o != 0);
        v.exp_run  = (r != 0);
        v.exp_pend = (p != 0);
        v.exp_wrap = (w != 0);
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One clock: inputs were set at the falling edge; return at the next
    // falling edge so outputs are sampled half a cycle after the rising edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int highs;
        int wraps;
        int cnt;

        reset     = 1'b0;
        count_enb = 1'b0;
        count     = '0;
        pwm_en    = 1'b0;
        duty_wr   = 1'b0;
        duty_in   = '0;
`ifdef PWM_POLARITY_EN
        pwm_pol   = 1'b0;
`endif

        // Vectors: count, enb, pwm_en, wr, din | out, running, pending, wrap_pulse
        vecs.push_back(mk( 10, 1, 0, 1,  64,  0, 0, 1, 0)); // shadow load while IDLE
        vecs.push_back(mk( 11, 1, 1, 0,   0,  0, 0, 1, 0)); // -> SYNC
        vecs.push_back(mk( 12, 1, 1, 0,   0,  0, 0, 1, 0)); // SYNC waits
        vecs.push_back(mk(255, 1, 1, 0,   0,  0, 1, 0, 1)); // wrap: RUN, apply 64
        vecs.push_back(mk(  0, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk( 63, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk( 64, 1, 1, 0,   0,  0, 1, 0, 0));
        vecs.push_back(mk(100, 1, 1, 1, 200,  0, 1, 1, 0)); // write 200 mid-period
        vecs.push_back(mk( 30, 1, 1, 0,   0,  1, 1, 1, 0)); // still 64 active
        vecs.push_back(mk(255, 1, 1, 0,   0,  0, 1, 0, 1)); // apply 200
        vecs.push_back(mk(150, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(199, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(200, 1, 1, 0,   0,  0, 1, 0, 0));
        vecs.push_back(mk(  5, 1, 1, 1,  30,  1, 1, 1, 0)); // write 30
        vecs.push_back(mk(  6, 1, 1, 1,  90,  1, 1, 1, 0)); // overwrite 90
        vecs.push_back(mk(255, 1, 1, 0,   0,  0, 1, 0, 1)); // apply 90
        vecs.push_back(mk( 89, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk( 90, 1, 1, 0,   0,  0, 1, 0, 0));
        vecs.push_back(mk( 10, 1, 1, 1,  20,  1, 1, 1, 0)); // pending 20
        vecs.push_back(mk(255, 1, 1, 1, 150,  0, 1, 0, 1)); // wrap write wins
        vecs.push_back(mk(149, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(150, 1, 1, 0,   0,  0, 1, 0, 0));
        vecs.push_back(mk(255, 0, 1, 0,   0,  0, 1, 0, 0)); // stalled: no wrap
        vecs.push_back(mk(100, 0, 1, 0,   0,  1, 1, 0, 0)); // stalled compare
        vecs.push_back(mk(128, 1, 0, 0,   0,  1, 1, 0, 0)); // -> STOPPING
        vecs.push_back(mk(129, 1, 0, 0,   0,  1, 1, 0, 0)); // period continues
        vecs.push_back(mk(255, 1, 0, 0,   0,  0, 0, 0, 1)); // -> IDLE
        vecs.push_back(mk(  0, 1, 0, 0,   0,  0, 0, 0, 0)); // IDLE holds low
        vecs.push_back(mk(  1, 1, 1, 0,   0,  0, 0, 0, 0)); // -> SYNC
        vecs.push_back(mk(  2, 1, 0, 0,   0,  0, 0, 0, 0)); // SYNC -> IDLE
        vecs.push_back(mk(  3, 1, 1, 0,   0,  0, 0, 0, 0)); // -> SYNC
        vecs.push_back(mk(255, 1, 1, 0,   0,  0, 1, 0, 1)); // -> RUN
        vecs.push_back(mk( 10, 1, 0, 0,   0,  1, 1, 0, 0)); // -> STOPPING
        vecs.push_back(mk(255, 1, 1, 0,   0,  0, 1, 0, 1)); // re-raise on wrap -> RUN
        vecs.push_back(mk(  0, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(255, 1, 0, 0,   0,  0, 1, 0, 1)); // RUN -> STOPPING on wrap
        vecs.push_back(mk(  0, 1, 0, 0,   0,  1, 1, 0, 0)); // last period runs
        vecs.push_back(mk(255, 1, 0, 0,   0,  0, 0, 0, 1)); // -> IDLE
        vecs.push_back(mk(255, 1, 0, 0,   0,  0, 0, 0, 1)); // wrap pulse in IDLE
        vecs.push_back(mk(255, 1, 1, 1, 255,  0, 0, 0, 1)); // duty 255, -> SYNC
        vecs.push_back(mk(255, 1, 1, 0,   0,  0, 1, 0, 1)); // -> RUN
        vecs.push_back(mk(254, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(255, 1, 1, 0,   0,  0, 1, 0, 1)); // only low count
        vecs.push_back(mk(  0, 1, 1, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(255, 1, 1, 1,   0,  0, 1, 0, 1)); // duty 0
        vecs.push_back(mk(  0, 1, 1, 0,   0,  0, 1, 0, 0));
        vecs.push_back(mk(128, 1, 1, 0,   0,  0, 1, 0, 0));

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_running", int'(pwm_running), 0);
        check("rst_pending", int'(duty_pending), 0);
        check("rst_wrap", int'(wrap_pulse), 0);
        reset = 1'b1;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            count     = vecs[i].count;
            count_enb = vecs[i].enb;
            pwm_en    = vecs[i].en;
            duty_wr   = vecs[i].wr;
            duty_in   = vecs[i].din;
            cycle();
            check($sformatf("v%0d_pwm_out", i), int'(pwm_out), int'(vecs[i].exp_out));
            check($sformatf("v%0d_running", i), int'(pwm_running), int'(vecs[i].exp_run));
            check($sformatf("v%0d_pending", i), int'(duty_pending), int'(vecs[i].exp_pend));
            check($sformatf("v%0d_wrap", i), int'(wrap_pulse), int'(vecs[i].exp_wrap));
        end

        // Full period with free-running counter, duty 64 applied on the wrap.
        count = 8'd255; count_enb = 1'b1; pwm_en = 1'b1; duty_wr = 1'b1; duty_in = 8'd64;
        cycle();
        duty_wr = 1'b0;
        highs = 0;
        wraps = 0;
        for (int i = 0; i < 256; i++) begin
            count = N'(i);
            cycle();
            highs += int'(pwm_out);
            wraps += int'(wrap_pulse);
        end
        check("period_high_clks", highs, 64);
        check("period_wraps", wraps, 1);

        // Counter enabled one cycle in three: period stretches to 768 clocks.
        highs = 0;
        wraps = 0;
        cnt   = 0;
        for (int j = 0; j < 768; j++) begin
            count     = N'(cnt);
            count_enb = (j % 3 == 0);
            cycle();
            if (count_enb) cnt = (cnt + 1) % 256;
            highs += int'(pwm_out);
            wraps += int'(wrap_pulse);
        end
        check("slow_high_clks", highs, 192);
        check("slow_wraps", wraps, 1);
        check("slow_count_back", cnt, 0);

        // Asynchronous reset mid-period with a pending shadow value.
        count = 8'd10; count_enb = 1'b1; duty_wr = 1'b1; duty_in = 8'd99;
        cycle();
        duty_wr = 1'b0;
        count   = 8'd40;
        cycle();
        check("pre_rst_pwm_out", int'(pwm_out), 1);
        check("pre_rst_pending", int'(duty_pending), 1);
        check("pre_rst_running", int'(pwm_running), 1);
        reset = 1'b0;
        #1;
        check("async_rst_pwm_out", int'(pwm_out), 0);
        check("async_rst_pending", int'(duty_pending), 0);
        check("async_rst_running", int'(pwm_running), 0);
        check("async_rst_wrap", int'(wrap_pulse), 0);
        @(negedge clk);
        reset = 1'b1;

        // After reset: IDLE with active duty 0, shadow discarded.
        count = 8'd255; pwm_en = 1'b0;
        cycle();
        check("post_rst_wrap", int'(wrap_pulse), 1);
        check("post_rst_pending", int'(duty_pending), 0);
        check("post_rst_running", int'(pwm_running), 0);
        count = 8'd0; pwm_en = 1'b1;
        cycle();
        check("post_rst_sync", int'(pwm_running), 0);
        count = 8'd255;
        cycle();
        check("post_rst_run", int'(pwm_running), 1);
        count = 8'd0;
        cycle();
        check("post_rst_duty0", int'(pwm_out), 0);
        count = 8'd1;
        cycle();
        check("post_rst_duty0_b", int'(pwm_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_compare_out.md
Name: pwm_compare_out

Overview:
- Downstream consumer of the free-running N-bit enable counter.
- Compares the counter value against a double-buffered duty register and produces one PWM output.
- Duty updates are written into a shadow register at any time and take effect only at the counter wrap (period boundary), so no glitched periods.
- A run-control FSM starts and stops the output only on period boundaries.

Parameters:
- N, 8, width of count and duty; period = 2^N counter enables.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- count_enb  input  1  same enable driving the counter; counter advances on clk edges where high.
- count  input  N  counter value; wraps 2^N-1 -> 0.
- pwm_en  input  1  level; request PWM running.
- duty_wr  input  1  single-cycle write strobe for duty_in.
- duty_in  input  N  new duty value (high counts per period).
- duty_pending  output  1  shadow holds a value not yet applied.
- pwm_running  output  1  high in RUN or STOPPING.
- pwm_out  output  1  registered PWM output.
- wrap_pulse  output  1  one-cycle pulse, registered, one clk after a wrap cycle.

Behaviour:
- Reset (reset=0, async): state IDLE, active_duty=0, shadow=0, duty_pending=0, pwm_out=0, wrap_pulse=0, pwm_running=0. Reset mid-period discards shadow and stops output immediately.
- wrap (internal, combinational) = count_enb && (count == all-ones). The counter shows 0 on the next cycle.
- Shadow write: duty_wr=1 loads shadow<=duty_in and sets duty_pending. A write while pending overwrites; the latest value wins.
- Apply: on a wrap cycle with duty_pending=1: active_duty<=shadow, duty_pending<=0.
- duty_wr on a wrap cycle: active_duty<=duty_in directly, duty_pending stays/clears to 0 (write bypasses shadow).
- FSM states: IDLE, SYNC, RUN, STOPPING.
  - IDLE: pwm_en=1 -> SYNC.
  - SYNC: pwm_en=0 -> IDLE. Otherwise wrap -> RUN.
  - RUN: pwm_en=0 -> STOPPING.
  - STOPPING: pwm_en=1 -> RUN. Otherwise wrap -> IDLE. The last period always completes.
  - pwm_en change on a wrap cycle: the pwm_en-based transition takes priority, e.g. STOPPING+pwm_en=1 -> RUN.
- pwm_out, latency 1 clk:
  - In RUN/STOPPING: pwm_out(t+1) = (count(t) < active_duty(t)).
  - In IDLE/SYNC: pwm_out(t+1) = 0.
  - duty=0 -> constantly 0. duty=2^N-1 -> low only while count = all-ones. 100% is not representable.
- pwm_running is registered from the state: 1 in RUN/STOPPING.
- wrap_pulse(t+1) = wrap(t), in every state including IDLE.
- Counter stalled (count_enb=0): no wraps, so duty is not applied, SYNC waits indefinitely, and pwm_out holds its compare result for the static count.
- Arithmetic is unsigned N-bit compare only; no internal counter.

Optional Feature:
- Macro PWM_POLARITY_EN.
- Defined:
  - Adds input port pwm_pol (1 bit).
  - In RUN/STOPPING, pwm_out = compare XOR pwm_pol.
  - In IDLE/SYNC, pwm_out = pwm_pol (idle level = inactive level).
  - After reset, pwm_out=0 until the first clk edge, then follows pwm_pol.
- Undefined: port absent; behaviour exactly as above (active-high, idle low).

Test Plan (N=8, count_enb=1 continuously unless stated):
- Reset, write duty 64, pwm_en=1 at count=10 -> SYNC until the wrap at count=255; RUN from count=0. pwm_out high for 64 clk (counts 0..63, 1-clk delayed), low 192 clk, repeating; wrap_pulse every 256 clk.
- RUN with duty 64; duty_wr 200 at count=100 -> duty_pending=1 and the current period stays 64 high. The next period is 200 high / 56 low; duty_pending drops the cycle after the wrap.
- Two writes 30 then 90 in one period -> next period is 90 high. duty_wr=1 with 150 exactly on the wrap cycle -> that next period is 150 high and duty_pending=0.
- Drop pwm_en at count=128 -> STOPPING; pwm_out completes the period, then IDLE and pwm_out=0. Re-raise pwm_en in STOPPING -> RUN with no gap.
- Edge duties: 0 -> pwm_out never high; 255 -> low exactly 1 clk per period. Toggle count_enb 1-of-3 cycles -> period = 768 clk, duty ratio preserved.
- Assert reset at count=40 in RUN with shadow pending -> all outputs 0 at once. After release: IDLE, duty_pending=0, active_duty=0.
